// File: rtl/snn_pixel_loader.sv
// Unpacks UART bytes LSB-first into 1-bit input-RAM writes; pulses core_start after a full frame, then waits for core_done.
// Optional SNN_LOADER_TIMEOUT_EN aborts a frame (frame_err pulse) after TIMEOUT_CYCLES of inter-byte silence.
module snn_pixel_loader #(
    parameter int NUM_BYTES      = 98,
    parameter int NUM_PIXELS     = 784,
    parameter int ADDR_W         = 10
`ifdef SNN_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2_500_000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_data,
    output logic              core_start,
    input  logic              core_done,
    output logic              busy,
    output logic              frame_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UNPACK    = 3'd1,
        WAIT_BYTE = 3'd2,
        START     = 3'd3,
        WAIT_CORE = 3'd4
    } state_t;

    localparam logic [6:0]        LAST_BYTE = 7'(NUM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_PIXELS - 1);

    state_t            state;
    logic [7:0]        shift;
    logic [7:0]        hold;
    logic              hold_vld;
    logic [2:0]        bit_cnt;
    logic [6:0]        byte_cnt;
    logic [ADDR_W-1:0] pix_cnt;

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int             GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(TIMEOUT_CYCLES - 1);
    logic [GAP_W-1:0] gap_cnt;
`endif

    // Write port is a pure decode of state registers, so it is glitch-free and never X.
    assign ram_we   = (state == UNPACK);
    assign ram_addr = pix_cnt;
    assign ram_data = shift[0];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            hold       <= '0;
            hold_vld   <= 1'b0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            pix_cnt    <= '0;
            core_start <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
            gap_cnt    <= '0;
            frame_err  <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
            frame_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rx_rdy) begin
                        shift    <= rx_data;
                        bit_cnt  <= '0;
                        byte_cnt <= byte_cnt + 7'd1;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (byte_cnt == LAST_BYTE) begin
                            hold_vld   <= 1'b0;
                            core_start <= 1'b1;
                            state      <= START;
                        end else if (hold_vld) begin
                            // Refill from the holding byte; a byte arriving now takes its place.
                            shift    <= hold;
                            byte_cnt <= byte_cnt + 7'd1;
                            hold_vld <= rx_rdy;
                            if (rx_rdy)
                                hold <= rx_data;
                        end else if (rx_rdy) begin
                            shift    <= rx_data;
                            byte_cnt <= byte_cnt + 7'd1;
                        end else begin
`ifdef SNN_LOADER_TIMEOUT_EN
                            gap_cnt <= '0;
`endif
                            state <= WAIT_BYTE;
                        end
                    end else if (rx_rdy && !hold_vld) begin
                        hold     <= rx_data;
                        hold_vld <= 1'b1;
                    end
                end
                WAIT_BYTE: begin
                    if (rx_rdy) begin
                        shift    <= rx_data;
                        bit_cnt  <= '0;
                        byte_cnt <= byte_cnt + 7'd1;
                        state    <= UNPACK;
                    end
`ifdef SNN_LOADER_TIMEOUT_EN
                    else if (gap_cnt == LAST_GAP) begin
                        frame_err <= 1'b1;
                        pix_cnt   <= '0;
                        byte_cnt  <= '0;
                        hold_vld  <= 1'b0;
                        hold      <= '0;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
`endif
                end
                START: begin
                    pix_cnt  <= '0;
                    byte_cnt <= '0;
                    hold_vld <= 1'b0;
                    state    <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SNN_LOADER_TIMEOUT_EN
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_pixel_loader.sv
// Directed self-checking bench for snn_pixel_loader: write log at negedge, hand-computed expectations.
`timescale 1ns/1ps
module tb_snn_pixel_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_data;
    logic              core_start;
    logic              core_done;
    logic              busy;
    logic              frame_err;

`ifdef SNN_LOADER_TIMEOUT_EN
    snn_pixel_loader #(.TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .core_start(core_start), .core_done(core_done), .busy(busy), .frame_err(frame_err)
    );
`else
    snn_pixel_loader dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .core_start(core_start), .core_done(core_done), .busy(busy), .frame_err(frame_err)
    );
`endif

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rdy_cyc;

    logic clr = 1'b0;
    int   wr_cnt, start_cnt, err_cnt, first_wr, last_wr, start_cyc, last_addr;
    logic mem_dat  [0:1023];
    int   mem_hits [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr) begin
            wr_cnt = 0; start_cnt = 0; err_cnt = 0;
            first_wr = -1; last_wr = -1; start_cyc = -1; last_addr = -1;
            for (int i = 0; i < 1024; i++) begin
                mem_dat[i]  = 1'b0;
                mem_hits[i] = 0;
            end
        end else begin
            if (ram_we) begin
                if (wr_cnt == 0) first_wr = cyc;
                last_wr   = cyc;
                last_addr = int'(ram_addr);
                mem_dat[ram_addr]  = ram_data;
                mem_hits[ram_addr] = mem_hits[ram_addr] + 1;
                wr_cnt++;
            end
            if (core_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (frame_err) err_cnt++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pack(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = mem_dat[base + i];
        return int'(b);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_rdy = 1'b1;
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        rdy_cyc = cyc;
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        clr_log();
    endtask

    initial begin
        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; core_done = 1'b0;
        idle(3);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_data", ram_data, 0);
        check("rst_core_start", core_start, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        idle(2);
        clr_log();

        // Reset asserted in the middle of unpacking takes effect without a clock edge
        send(8'h55);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_we", ram_we, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_addr", int'(ram_addr), 0);
        check("async_rst_data", ram_data, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        clr_log();

        // First byte 0xA5 lands at addr 0..7, LSB first
        send(8'hA5);
        idle(12);
        check("a5_wr_cnt", wr_cnt, 8);
        check("a5_first_cycle", first_wr, rdy_cyc);
        check("a5_last_cycle", last_wr, rdy_cyc + 7);
        check("a5_bits", pack(0), 8'hA5);
        check("a5_last_addr", last_addr, 7);

        // Full frame of 0x01 bytes
        do_reset();
        for (int i = 0; i < 98; i++) begin
            send(8'h01);
            idle(18);
        end
        idle(20);
        begin
            int bad = 0;
            for (int a = 0; a < 784; a++)
                if (mem_hits[a] != 1 || mem_dat[a] != ((a % 8) == 0)) bad++;
            check("frame_bad_pixels", bad, 0);
        end
        check("frame_wr_cnt", wr_cnt, 784);
        check("frame_last_addr", last_addr, 783);
        check("frame_start_cnt", start_cnt, 1);
        check("frame_start_cycle", start_cyc, last_wr + 1);
        check("frame_busy", busy, 1);

        // Bytes arriving while waiting for the core are dropped
        clr_log();
        for (int i = 0; i < 5; i++) begin
            send(8'hFF);
            idle(198);
        end
        check("wait_core_wr_cnt", wr_cnt, 0);
        check("wait_core_busy", busy, 1);
        check("wait_core_start", start_cnt, 0);
        @(posedge clk);
        #1 core_done = 1'b1;
        @(posedge clk);
        #1 core_done = 1'b0;
        idle(1);
        check("done_busy", busy, 0);
        send(8'h3C);
        idle(12);
        check("next_frame_wr_cnt", wr_cnt, 8);
        check("next_frame_bits", pack(0), 8'h3C);
        check("next_frame_last_addr", last_addr, 7);

        // Holding register: 0xFF, 0x00 two cycles apart, 0xAA dropped while hold full
        do_reset();
        send(8'hFF);
        send(8'h00);
        send(8'hAA);
        idle(24);
        check("hold_wr_cnt", wr_cnt, 16);
        check("hold_span", last_wr - first_wr, 15);
        check("hold_byte0", pack(0), 8'hFF);
        check("hold_byte1", pack(8), 8'h00);
        send(8'h81);
        idle(12);
        check("hold_after_drop_cnt", wr_cnt, 24);
        check("hold_after_drop_byte", pack(16), 8'h81);
        check("hold_after_drop_addr", last_addr, 23);

        // Byte arriving on the final unpack cycle follows with no write gap
        do_reset();
        send(8'h0F);
        repeat (6) @(posedge clk);
        send(8'hF0);
        idle(20);
        check("edge_wr_cnt", wr_cnt, 16);
        check("edge_span", last_wr - first_wr, 15);
        check("edge_byte0", pack(0), 8'h0F);
        check("edge_byte1", pack(8), 8'hF0);

        // Long silence after 10 bytes
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(8'h11);
            idle(12);
        end
        idle(1100);
`ifdef SNN_LOADER_TIMEOUT_EN
        check("timeout_err_cnt", err_cnt, 1);
        check("timeout_busy", busy, 0);
        send(8'hC3);
        idle(12);
        check("timeout_restart_bits", pack(0), 8'hC3);
        check("timeout_restart_addr", last_addr, 7);
`else
        check("silence_err_cnt", err_cnt, 0);
        check("silence_busy", busy, 1);
        send(8'hC3);
        idle(12);
        check("silence_resume_bits", pack(80), 8'hC3);
        check("silence_resume_addr", last_addr, 87);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
